x7seg_capture: RTL and testbench
================================

X7SEG_CAPTURE -- requirements
Module: x7seg_capture

Interface
REQ-001 SETTLE, 2, consecutive identical sampled cycles required before a digit is accepted (legal range 1..15).
REQ-002 cclk  in  1  capture clock; all state updates on rising edge.
REQ-003 clr  in  1  reset, asynchronous, active-high.
REQ-004 a_to_g  in  7  active-low segment cathodes; bit 6 = a ... bit 0 = g.
REQ-005 an  in  4  active-low digit anodes; an[0] = least significant nibble.
REQ-006 dp  in  1  decimal point cathode; sampled and ignored.
REQ-007 x  out  16  last complete captured value.
REQ-008 valid  out  1  one-cycle pulse when x is updated.
REQ-009 seen  out  4  digits captured in the current frame.
REQ-010 err  out  1  sticky flag: illegal segment pattern or multiple active anodes.
REQ-011 err_cnt  out  8  error event count (see Configuration).

Function
REQ-012 The block SHALL register a_to_g and an once (sample stage) before any other use; all latencies below count from that sample.
REQ-013 The block SHALL implement states WAIT, SETTLE, HOLD.
REQ-014 WAIT: sample has no low anode bit (4'hF) -> stay; exactly one low bit -> SETTLE with count = 1; two or more low bits -> error event, stay.
REQ-015 SETTLE: sample equal to previous sample -> count + 1; otherwise -> re-evaluate the sample as in WAIT; when count reaches SETTLE -> accept the digit and go to HOLD in the same cycle.
REQ-016 HOLD: stay while sample is unchanged; on any change -> re-evaluate the sample as in WAIT.
REQ-017 Accept: decode a_to_g per table 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex, 7-bit); write the nibble into shadow[idx] and set seen[idx], where idx is the low anode bit.
REQ-018 Pattern not in the table -> error event; shadow and seen unchanged; state -> HOLD.
REQ-019 Accept of an already-seen idx SHALL overwrite shadow[idx]; seen unchanged.
REQ-020 When an accept makes seen = 4'hF, the block SHALL on the next edge load x from shadow (including the new nibble), pulse valid high for exactly 1 cycle, and clear seen to 0.
REQ-021 Minimum latency from a stable digit on the pins to its accept SHALL be 1 + SETTLE cycles.
REQ-022 Error event SHALL set err (held until clr) and does not affect x, valid or frame progress of other digits.
REQ-023 dp SHALL have no effect on any output.

Reset
REQ-024 clr high SHALL asynchronously force x = 16'h0000, valid = 0, seen = 4'h0, err = 0, err_cnt = 8'h00, shadow = 0, state = WAIT, count = 0, sample = {7'h7F, 4'hF}.
REQ-025 clr asserted mid-frame or mid-settle SHALL discard the partial frame; capture restarts from WAIT after release.

Configuration
REQ-026 Macro X7SEG_CAPTURE_ERRCNT_EN defined: err_cnt SHALL increment by 1 per error event, saturating at 8'hFF.
REQ-027 Macro undefined: err_cnt SHALL be constant 8'h00 with no counter logic; all other behaviour identical.

Verification
REQ-028 Drive digits 0..3 round-robin with values 4,3,2,1 (an=E,D,B,7), 4 cycles each, SETTLE=2 -> valid pulse once per round, x = 16'h1234, err = 0.
REQ-029 Hold an=E with a_to_g toggling between 40 and 79 every cycle -> no accept, seen stays 0, no valid.
REQ-030 Drive an=C (two digits active) for 3 cycles -> err = 1; with macro err_cnt = 1, without macro err_cnt = 0.
REQ-031 Drive an=E, a_to_g=7F (blank) for 4 cycles -> err = 1, seen[0] = 0; then frame F,F,F,F -> x = 16'hFFFF, valid pulses.
REQ-032 Capture digits 0..2 (seen = 4'h7), pulse clr for 1 cycle, then full frame A,B,C,D -> seen = 0 immediately at clr, single valid with x = 16'hDCBA.
REQ-033 With macro, inject 300 error events -> err_cnt saturates at 8'hFF.

Source files
------------

// File: rtl/x7seg_capture.sv
// x7seg_capture: recovers a 16-bit value from a multiplexed, active-low
// 7-segment display bus. Each digit is accepted once its pins have held
// still for SETTLE sampled cycles. A full frame is published on x when all
// four digits have been seen.
// Optional feature: define X7SEG_CAPTURE_ERRCNT_EN to build the saturating
// error event counter on err_cnt. Left undefined, err_cnt is tied to zero.
module x7seg_capture #(
    parameter int unsigned SETTLE = 2      // legal range 1..15
) (
    input  logic        cclk,
    input  logic        clr,
    input  logic [6:0]  a_to_g,
    input  logic [3:0]  an,
    input  logic        dp,
    output logic [15:0] x,
    output logic        valid,
    output logic [3:0]  seen,
    output logic        err,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {ST_WAIT, ST_SETTLE, ST_HOLD} state_t;

    localparam logic [4:0] SETTLE_N = 5'(SETTLE);

    // Sample stage and the sample from one cycle earlier.
    logic [6:0] s_seg, p_seg;
    logic [3:0] s_an,  p_an;
    logic       dp_unused;

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       take;          // settle complete this cycle: try to accept
    logic       bad_an;        // multiple-anode error event

    // Outcome of evaluating the current sample from scratch.
    state_t     ev_state;
    logic [3:0] ev_cnt;
    logic       ev_take;
    logic       ev_bad;

    logic       changed;
    logic       one_low;
    logic       no_low;
    logic [1:0] idx;

    logic [3:0][3:0] shadow;
    logic       done;          // last accept completed the frame
    logic       done_nx;
    logic       legal;
    logic [3:0] nib;
    logic       wr;
    logic       evt;
    logic [3:0] seen_nx;

    // Seven-segment pattern to nibble; bit 4 flags a legal pattern.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h40:   r = 5'h10;
            7'h79:   r = 5'h11;
            7'h24:   r = 5'h12;
            7'h30:   r = 5'h13;
            7'h19:   r = 5'h14;
            7'h12:   r = 5'h15;
            7'h02:   r = 5'h16;
            7'h78:   r = 5'h17;
            7'h00:   r = 5'h18;
            7'h10:   r = 5'h19;
            7'h08:   r = 5'h1A;
            7'h03:   r = 5'h1B;
            7'h46:   r = 5'h1C;
            7'h21:   r = 5'h1D;
            7'h06:   r = 5'h1E;
            7'h0E:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // Register the pins once; every decision below works on these samples.
    // dp is sampled alongside the bus but has no consumer.
    always_ff @(posedge cclk or posedge clr) begin
        if (clr) begin
            s_seg     <= 7'h7F;
            s_an      <= 4'hF;
            p_seg     <= 7'h7F;
            p_an      <= 4'hF;
            dp_unused <= 1'b0;
        end else begin
            s_seg     <= a_to_g;
            s_an      <= an;
            p_seg     <= s_seg;
            p_an      <= s_an;
            dp_unused <= dp;
        end
    end

    assign changed = {s_seg, s_an} != {p_seg, p_an};

    // Classify the anode sample: none, exactly one, or several low bits.
    always_comb begin
        one_low = 1'b1;
        no_low  = 1'b0;
        idx     = 2'd0;
        case (s_an)
            4'hE:    idx = 2'd0;
            4'hD:    idx = 2'd1;
            4'hB:    idx = 2'd2;
            4'h7:    idx = 2'd3;
            4'hF: begin
                one_low = 1'b0;
                no_low  = 1'b1;
            end
            default: one_low = 1'b0;
        endcase
    end

    // Fresh evaluation of the sample, as seen from WAIT. A multi-anode
    // sample only raises an event when it is new, so a held fault counts once.
    always_comb begin
        ev_state = ST_WAIT;
        ev_cnt   = 4'd0;
        ev_take  = 1'b0;
        ev_bad   = 1'b0;
        if (one_low) begin
            ev_cnt = 4'd1;
            if (SETTLE_N <= 5'd1) begin
                ev_take  = 1'b1;
                ev_state = ST_HOLD;
            end else begin
                ev_state = ST_SETTLE;
            end
        end else if (!no_low) begin
            ev_bad = changed;
        end
    end

    // State register.
    always_ff @(posedge cclk or posedge clr) begin
        if (clr) begin
            state <= ST_WAIT;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        take     = 1'b0;
        bad_an   = 1'b0;
        case (state)
            ST_WAIT: begin
                state_nx = ev_state;
                cnt_nx   = ev_cnt;
                take     = ev_take;
                bad_an   = ev_bad;
            end
            ST_SETTLE: begin
                if (!changed) begin
                    cnt_nx = cnt + 4'd1;
                    if (({1'b0, cnt} + 5'd1) >= SETTLE_N) begin
                        take     = 1'b1;
                        state_nx = ST_HOLD;
                    end
                end else begin
                    state_nx = ev_state;
                    cnt_nx   = ev_cnt;
                    take     = ev_take;
                    bad_an   = ev_bad;
                end
            end
            ST_HOLD: begin
                if (changed) begin
                    state_nx = ev_state;
                    cnt_nx   = ev_cnt;
                    take     = ev_take;
                    bad_an   = ev_bad;
                end
            end
            default: begin
                state_nx = ST_WAIT;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    // Output logic: decode on accept, frame bookkeeping, error events.
    // A frame completed last cycle clears seen before this cycle's accept
    // is merged in, so a back-to-back accept starts the next frame.
    always_comb begin
        {legal, nib} = seg_decode(s_seg);
        wr       = take & legal;
        evt      = bad_an | (take & ~legal);
        seen_nx  = done ? 4'h0 : seen;
        if (wr)
            seen_nx = seen_nx | (4'b0001 << idx);
        done_nx  = wr & (seen_nx == 4'hF);
    end

    // Shadow digits, frame publication and sticky error flag.
    always_ff @(posedge cclk or posedge clr) begin
        if (clr) begin
            shadow <= '0;
            seen   <= 4'h0;
            done   <= 1'b0;
            x      <= 16'h0000;
            valid  <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (wr)
                shadow[idx] <= nib;
            seen  <= seen_nx;
            done  <= done_nx;
            valid <= done;
            if (done)
                x <= shadow;
            if (evt)
                err <= 1'b1;
        end
    end

`ifdef X7SEG_CAPTURE_ERRCNT_EN
    // Saturating count of error events.
    always_ff @(posedge cclk or posedge clr) begin
        if (clr)
            err_cnt <= 8'h00;
        else if (evt && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'h01;
    end
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_x7seg_capture.sv
// Scoreboard bench for x7seg_capture: stimulus pushes expected frame values,
// a monitor pops one per valid pulse; state flags are checked directly.
module tb_x7seg_capture;

    logic        cclk = 1'b0;
    logic        clr  = 1'b1;
    logic [6:0]  a_to_g = 7'h7F;
    logic [3:0]  an = 4'hF;
    logic        dp = 1'b0;
    logic [15:0] x;
    logic        valid;
    logic [3:0]  seen;
    logic        err;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

`ifdef X7SEG_CAPTURE_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    x7seg_capture #(.SETTLE(2)) dut (
        .cclk(cclk), .clr(clr), .a_to_g(a_to_g), .an(an), .dp(dp),
        .x(x), .valid(valid), .seen(seen), .err(err), .err_cnt(err_cnt)
    );

    always #5 cclk = ~cclk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Hold a pin pattern for n cycles; dp wiggles to show it is ignored.
    task automatic drive(input logic [6:0] seg, input logic [3:0] a, input int n);
        a_to_g = seg;
        an     = a;
        repeat (n) begin
            dp = 1'($urandom);
            @(negedge cclk);
        end
    endtask

    // Monitor: every valid pulse must match the oldest expected frame.
    always @(negedge cclk) begin
        if (!clr && valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got x=%h with no frame expected", x);
            end else begin
                chk("frame_x", x, exp_q.pop_front());
            end
        end
    end

    initial begin
        int t;
        repeat (3) @(negedge cclk);
        chk("rst_x", x, 16'h0000);
        chk("rst_valid", 16'(valid), 16'h0);
        chk("rst_seen", 16'(seen), 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        chk("rst_err_cnt", 16'(err_cnt), 16'h0);
        clr = 1'b0;
        drive(7'h7F, 4'hF, 3);

        // Round robin 4,3,2,1 on digits 0..3: one frame per round.
        for (int r = 0; r < 3; r++) begin
            exp_q.push_back(16'h1234);
            drive(7'h19, 4'hE, 4);
            drive(7'h30, 4'hD, 4);
            drive(7'h24, 4'hB, 4);
            drive(7'h79, 4'h7, 4);
        end
        drive(7'h7F, 4'hF, 6);
        chk("rr_x", x, 16'h1234);
        chk("rr_err", 16'(err), 16'h0);
        chk("rr_seen", 16'(seen), 16'h0);

        // Segments toggle every cycle: never settles.
        for (int i = 0; i < 12; i++)
            drive((i % 2) ? 7'h79 : 7'h40, 4'hE, 1);
        drive(7'h7F, 4'hF, 4);
        chk("toggle_seen", 16'(seen), 16'h0);
        chk("toggle_err", 16'(err), 16'h0);

        // Blank pattern on digit 0 is illegal; then an all-F frame.
        drive(7'h7F, 4'hE, 4);
        chk("blank_err", 16'(err), 16'h1);
        chk("blank_seen", 16'(seen), 16'h0);
        chk("blank_err_cnt", 16'(err_cnt), CNT_EN ? 16'h1 : 16'h0);
        exp_q.push_back(16'hFFFF);
        drive(7'h0E, 4'hE, 4);
        drive(7'h0E, 4'hD, 4);
        drive(7'h0E, 4'hB, 4);
        drive(7'h0E, 4'h7, 4);
        drive(7'h7F, 4'hF, 6);
        chk("fff_x", x, 16'hFFFF);

        // Two anodes low for three cycles: a single error event.
        clr = 1'b1;
        @(negedge cclk);
        clr = 1'b0;
        chk("clr_err", 16'(err), 16'h0);
        drive(7'h40, 4'hC, 3);
        drive(7'h7F, 4'hF, 3);
        chk("multi_err", 16'(err), 16'h1);
        chk("multi_err_cnt", 16'(err_cnt), CNT_EN ? 16'h1 : 16'h0);
        chk("multi_seen", 16'(seen), 16'h0);

        // Accept latency is 1 + SETTLE edges from the pins.
        a_to_g = 7'h40;
        an     = 4'hE;
        @(negedge cclk);
        @(negedge cclk);
        chk("latency_early", 16'(seen), 16'h0);
        @(negedge cclk);
        chk("latency_accept", 16'(seen), 16'h1);
        drive(7'h40, 4'hE, 1);
        drive(7'h79, 4'hD, 4);
        drive(7'h24, 4'hB, 4);
        chk("partial_seen", 16'(seen), 16'h7);

        // clr mid-frame drops the partial frame at once.
        a_to_g = 7'h7F;
        an     = 4'hF;
        clr    = 1'b1;
        #1;
        chk("clr_async_seen", 16'(seen), 16'h0);
        chk("clr_async_x", x, 16'h0000);
        @(negedge cclk);
        clr = 1'b0;
        exp_q.push_back(16'hDCBA);
        drive(7'h08, 4'hE, 4);
        drive(7'h03, 4'hD, 4);
        drive(7'h46, 4'hB, 4);
        drive(7'h21, 4'h7, 4);
        drive(7'h7F, 4'hF, 6);
        chk("dcba_x", x, 16'hDCBA);
        chk("dcba_seen", 16'(seen), 16'h0);

        // 300 distinct multi-anode events: counter saturates.
        for (int i = 0; i < 150; i++) begin
            drive(7'h40, 4'hC, 1);
            drive(7'h40, 4'h3, 1);
        end
        drive(7'h7F, 4'hF, 3);
        chk("sat_err_cnt", 16'(err_cnt), CNT_EN ? 16'h00FF : 16'h0000);
        chk("sat_err", 16'(err), 16'h1);

        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge cclk);
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL frame_timeout: got %0d frames outstanding expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
